// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: pattern modes and bounce direction.
package led_pkg;

   typedef enum logic [1:0] {
      MODE_ROT_L  = 2'd0,
      MODE_ROT_R  = 2'd1,
      MODE_BOUNCE = 2'd2,
      MODE_FILL   = 2'd3
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/led_prescaler.sv
// Step prescaler: counts enabled cycles 0..DIV-1 and flags the last one as a tick.
module led_prescaler #(
   parameter int unsigned DIV = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // tick is combinational from en so the pattern engine registers on the same edge
   always_comb begin
      tick  = en && (cnt_q == CNT_MAX);
      cnt_d = cnt_q;
      if (en) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: rotate-left/right, bounce and fill, advancing one step per prescaler tick.
module led_sequencer
   import led_pkg::*;
#(
   parameter int unsigned N_LED      = 8,
   parameter int unsigned DIV        = 1000000,
   parameter bit          ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   output logic [N_LED-1:0] led,
   output logic             step
);

   localparam int unsigned IW = $clog2(N_LED);
   localparam logic [IW-1:0] IDX_MAX = IW'(N_LED - 1);
   localparam logic [IW-1:0] IDX_ONE = IW'(1);
   localparam logic [N_LED-1:0] LIT0 = N_LED'(1);
   localparam logic [N_LED-1:0] LED_RST = ACTIVE_LOW ? ~LIT0 : LIT0;

   logic          tick;
   logic [IW-1:0] idx_q, idx_d;
   dir_e          dir_q, dir_d;
   mode_e         mode_q, mode_d;
   logic [N_LED-1:0] led_q, led_d;
   logic          step_q, step_d;

   function automatic logic [N_LED-1:0] lit_vec(input logic [IW-1:0] idx, input mode_e m);
      logic [N_LED-1:0] v;
      v = '0;
      for (int unsigned i = 0; i < N_LED; i++) begin
         v[i] = (m == MODE_FILL) ? (i <= 32'(idx)) : (i == 32'(idx));
      end
      return v;
   endfunction

   function automatic logic [N_LED-1:0] drive(input logic [N_LED-1:0] lit);
      return ACTIVE_LOW ? ~lit : lit;
   endfunction

   led_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .tick (tick)
   );

   always_comb begin
      idx_d  = idx_q;
      dir_d  = dir_q;
      mode_d = mode_q;
      led_d  = led_q;
      step_d = 1'b0;
      if (tick) begin
         step_d = 1'b1;
         if (mode_e'(mode) != mode_q) begin
            mode_d = mode_e'(mode);
            idx_d  = '0;
            dir_d  = DIR_UP;
         end else begin
            case (mode_q)
               MODE_ROT_R: idx_d = (idx_q == '0) ? IDX_MAX : idx_q - 1'b1;
               MODE_BOUNCE: begin
                  // endpoints turn around immediately so neither end dwells for two steps
                  if (dir_q == DIR_UP) begin
                     if (idx_q == IDX_MAX) begin
                        dir_d = DIR_DOWN;
                        idx_d = IDX_MAX - 1'b1;
                     end else begin
                        idx_d = idx_q + 1'b1;
                     end
                  end else begin
                     if (idx_q == '0) begin
                        dir_d = DIR_UP;
                        idx_d = IDX_ONE;
                     end else begin
                        idx_d = idx_q - 1'b1;
                     end
                  end
               end
               default: idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            endcase
         end
         led_d = drive(lit_vec(idx_d, mode_d));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx_q  <= '0;
         dir_q  <= DIR_UP;
         mode_q <= MODE_ROT_L;
         led_q  <= LED_RST;
         step_q <= 1'b0;
      end else begin
         idx_q  <= idx_d;
         dir_q  <= dir_d;
         mode_q <= mode_d;
         led_q  <= led_d;
         step_q <= step_d;
      end
   end

   assign led  = led_q;
   assign step = step_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: directed pattern scenarios plus random en/mode/reset against a step-count model.
module tb_led_sequencer;

   localparam int N = 8;
   localparam int D = 4;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic [N-1:0] led;
   logic       step;

   int checks;
   int errors;

   // model: enabled-cycle count within a step, applied mode, steps taken since mode applied
   int m_ecnt;
   int m_mode;
   int m_k;
   bit m_step;

   led_sequencer #(
      .N_LED      (N),
      .DIV        (D),
      .ACTIVE_LOW (1'b1)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .led  (led),
      .step (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int m_idx();
      int p;
      case (m_mode)
         0: return m_k % N;
         1: return (N - (m_k % N)) % N;
         2: begin
            p = m_k % (2 * N - 2);
            return (p < N) ? p : (2 * N - 2 - p);
         end
         default: return m_k % N;
      endcase
   endfunction

   function automatic logic [N-1:0] m_led();
      longint lit;
      int idx;
      idx = m_idx();
      if (m_mode == 3) lit = (64'd1 << (idx + 1)) - 64'd1;
      else             lit = 64'd1 << idx;
      return ~lit[N-1:0];
   endfunction

   function automatic void m_reset();
      m_ecnt = 0;
      m_mode = 0;
      m_k    = 0;
      m_step = 1'b0;
   endfunction

   task automatic cycle();
      @(posedge clk);
      m_step = 1'b0;
      if (rst && en) begin
         m_ecnt++;
         if (m_ecnt == D) begin
            m_ecnt = 0;
            m_step = 1'b1;
            if (int'(mode) != m_mode) begin
               m_mode = int'(mode);
               m_k    = 0;
            end else begin
               m_k++;
            end
         end
      end
      #1;
      check("led", 32'(led), 32'(m_led()));
      check("step", 32'(step), 32'(m_step));
   endtask

   task automatic apply_reset();
      #2 rst = 1'b0;
      m_reset();
      #1;
      check("rst_led", 32'(led), 32'hFE);
      check("rst_step", 32'(step), 32'd0);
      cycle();
      cycle();
      rst = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst  = 1'b1;
      en   = 1'b0;
      mode = 2'd0;
      m_reset();
      #1;

      // rotate-left from reset, first step four cycles after release, then wrap
      en = 1'b1;
      apply_reset();
      run(3);
      cycle();
      check("rotl_first_led", 32'(led), 32'hFD);
      check("rotl_first_step", 32'(step), 32'd1);
      run(4 * 6);
      check("rotl_step7", 32'(led), 32'h7F);
      run(4);
      check("rotl_wrap", 32'(led), 32'hFE);

      // rotate-right: mode change step, then wrap down to bit 7
      mode = 2'd1;
      apply_reset();
      run(4);
      check("rotr_chg", 32'(led), 32'hFE);
      run(4);
      check("rotr_s1", 32'(led), 32'h7F);
      run(4);
      check("rotr_s2", 32'(led), 32'hBF);

      // bounce full sweep and one beyond
      mode = 2'd2;
      apply_reset();
      run(4 * 17);

      // fill
      mode = 2'd3;
      apply_reset();
      run(4 * 8);
      check("fill_full", 32'(led), 32'h00);
      run(4);
      check("fill_wrap", 32'(led), 32'hFE);

      // pause at cnt=2 with mode toggling, then resume
      mode = 2'd0;
      apply_reset();
      run(2);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) mode = 2'd2;
         if (i == 6) mode = 2'd0;
         cycle();
      end
      check("pause_led", 32'(led), 32'hFE);
      en = 1'b1;
      cycle();
      check("resume_nostep", 32'(step), 32'd0);
      cycle();
      check("resume_step", 32'(step), 32'd1);
      check("resume_led", 32'(led), 32'hFD);
      mode = 2'd2;
      cycle();
      mode = 2'd0;
      run(3);
      check("toggle_noreinit", 32'(led), 32'hFB);

      // async reset mid-bounce at idx 5 going down
      mode = 2'd2;
      apply_reset();
      run(4 * 10 + 2);
      check("bounce_idx5", 32'(led), 32'hDF);
      apply_reset();
      run(3);
      check("post_rst_nostep", 32'(step), 32'd0);
      cycle();
      check("post_rst_step", 32'(step), 32'd1);

      // random en / mode / reset
      for (int i = 0; i < 2000; i++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 299) == 0) apply_reset();
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
